request_returner: RTL
=====================

Name: request_returner

Overview:
- Sits directly downstream of the burst handler.
- Accepts one completed request per cycle on the returner interface: read data returned from DRAM, or a write completion.
- Sorts completions into a read-response queue and a write-acknowledge queue, and drains each to the front end over independent valid/ready channels.
- The burst handler has no backpressure, so this block never stalls its input. It flags a queue that is nearly full, and records any overflow as a sticky error.

Parameters:
- DATA_WIDTH, 16, width of read data (matches types_def data_width)
- INDEX_WIDTH, 6, request index width (matches types_def read_entries_log)
- RD_DEPTH, 16, read-response queue entries (power of 2, >=4)
- WR_DEPTH, 16, write-ack queue entries (power of 2, >=4)
- AF_MARGIN, 2, almost_full asserts when free entries <= AF_MARGIN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  completion present this cycle (returner_valid)
- in_type  in  r_type  read or write (returner_type)
- in_data  in  DATA_WIDTH  read data; ignored for write
- in_index  in  INDEX_WIDTH  originating request index
- rd_valid  out  1  read response available
- rd_ready  in  1  front end accepts read response
- rd_data  out  DATA_WIDTH  read response data
- rd_index  out  INDEX_WIDTH  read response index
- wr_valid  out  1  write ack available
- wr_ready  in  1  front end accepts write ack
- wr_index  out  INDEX_WIDTH  write ack index
- rd_count  out  $clog2(RD_DEPTH)+1  read queue occupancy
- wr_count  out  $clog2(WR_DEPTH)+1  write queue occupancy
- rd_almost_full  out  1  RD_DEPTH-rd_count <= AF_MARGIN
- wr_almost_full  out  1  WR_DEPTH-wr_count <= AF_MARGIN
- overflow  out  1  sticky: a completion was dropped

Behaviour:
- Reset (rst_n=0 at posedge): pointers, counts, overflow, valids all 0; rd_data=0, rd_index=0, wr_index=0. Queue contents need no reset. Reset mid-operation discards all queued entries; the first post-reset completion is accepted on the next posedge with rst_n=1.
- Routing: in_valid && in_type==read pushes {in_data,in_index} into the read queue; in_valid && in_type==write pushes in_index into the write queue. in_valid=0 pushes nothing.
- Queues are first-word-fall-through:
  - an entry pushed at posedge N appears on rd_valid/wr_valid during cycle N+1;
  - valid = (count != 0);
  - output fields show the head entry and are forced to 0 when the queue is empty.
- Pop rule: a channel pops at a posedge when valid && ready. ready while not valid has no effect. Outputs must stay stable while valid && !ready.
- Simultaneous push and pop on the same queue: both occur and the count is unchanged. This holds when full, so a full queue with ready=1 accepts the new entry.
- Push to a full queue without a same-cycle pop: the entry is dropped, the queue is unchanged, and overflow sets at that posedge and holds until reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is one bit wider and saturates at DEPTH/0 by construction. Ordering is strict FIFO per queue; there is no ordering between the read and write queues.
- The two channels are fully independent: both may fire in the same cycle.
- almost_full, count and valid are registered-state derived, combinational from occupancy only, with no input-to-output combinational path.

Decomposition:
- Package types_def already holds r_type (read/write), data_width and read_entries_log; reuse them.
- Add RET_RD_DEPTH and RET_WR_DEPTH localparams to types_def so the burst handler and front end can size credits.
- One sub-module, ret_fifo: parameterised WIDTH/DEPTH/AF_MARGIN FWFT queue with push, pop, count, full, almost_full and drop_pulse. It is instantiated twice (read queue WIDTH=DATA_WIDTH+INDEX_WIDTH, write queue WIDTH=INDEX_WIDTH). The top holds the routing and the sticky overflow flag.

Test Plan:
- Reset, then a single read completion (data=16'hBEEF, index=5), rd_ready=1 -> rd_valid=1 in the following cycle with rd_data=BEEF, rd_index=5; pop; rd_count returns to 0; wr_valid stays 0.
- Interleaved stream R(idx1), W(idx2), R(idx3), W(idx4) on consecutive cycles, both readies=0 -> rd_count=2, wr_count=2. Raise both readies -> rd order 1,3 and wr order 2,4, with rd and wr popping in the same cycles.
- Push 14 reads with rd_ready=0 (depth 16, margin 2) -> rd_almost_full=1 after the 14th push, 0 while rd_count<=13. Push 2 more -> count=16, overflow=0.
- Read queue full, push a 17th read with rd_ready=0 -> dropped, overflow=1 sticky, count stays 16, head unchanged. Same cycle push+pop on full with rd_ready=1 -> count stays 16, no overflow.
- Wrap-around: 40 reads with random rd_ready (~50%) and occupancy kept below 16 -> all 40 indices come out in order with matching data; valid/data held stable during every ready=0 stall.
- Assert rst_n=0 with 5 entries queued in each queue and overflow=1 -> next cycle counts=0, valids=0, overflow=0, outputs 0. A completion presented in the first cycle after rst_n=1 is accepted.

Source files
------------

// File: rtl/types_def.sv
// Shared memory-controller types and sizing constants used by the burst
// handler, the request returner and the front end.
package types_def;

  typedef enum logic {
    RT_READ  = 1'b0,
    RT_WRITE = 1'b1
  } r_type;

  localparam int data_width       = 16;
  localparam int read_entries_log = 6;

  // Completion queue depths, exported so upstream/downstream can size credits.
  localparam int RET_RD_DEPTH = 16;
  localparam int RET_WR_DEPTH = 16;

endpackage

// File: rtl/request_returner_if.sv
// Completion input, read-response and write-ack channels of the request returner.
// Handshake: a channel transfers at a posedge where valid && ready; valid and
// payload come from registered occupancy only and hold steady until the transfer.
interface request_returner_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 6,
  parameter int RD_DEPTH    = 16,
  parameter int WR_DEPTH    = 16
);
  import types_def::*;

  logic                      in_valid;
  r_type                     in_type;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [INDEX_WIDTH-1:0]    in_index;

  logic                      rd_valid;
  logic                      rd_ready;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic [INDEX_WIDTH-1:0]    rd_index;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [INDEX_WIDTH-1:0]    wr_index;

  logic [$clog2(RD_DEPTH):0] rd_count;
  logic [$clog2(WR_DEPTH):0] wr_count;
  logic                      rd_almost_full;
  logic                      wr_almost_full;
  logic                      rd_full;
  logic                      wr_full;
  logic                      overflow;

  modport slave (
    input  in_valid, in_type, in_data, in_index, rd_ready, wr_ready,
    output rd_valid, rd_data, rd_index, wr_valid, wr_index,
           rd_count, wr_count, rd_almost_full, wr_almost_full,
           rd_full, wr_full, overflow
  );

  modport master (
    output in_valid, in_type, in_data, in_index, rd_ready, wr_ready,
    input  rd_valid, rd_data, rd_index, wr_valid, wr_index,
           rd_count, wr_count, rd_almost_full, wr_almost_full,
           rd_full, wr_full, overflow
  );

endinterface

// File: rtl/request_returner_ret_fifo.sv
// First-word-fall-through completion queue; a push into a full queue is dropped
// unless the same edge also pops, and the drop is reported on drop_pulse.
module ret_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    almost_full,
  output logic                    drop_pulse
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] AF_CNT   = (PW+1)'(DEPTH - AF_MARGIN);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid       = (count != '0);
  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);
  assign do_pop      = pop && valid;
  // A pop on the same edge frees the slot, so a full queue still accepts.
  assign do_push     = push && (!full || do_pop);
  assign drop_pulse  = push && full && !do_pop;
  assign head        = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/request_returner.sv
// Sorts burst-handler completions into a read-response queue and a write-ack
// queue; the input never stalls, so lost completions latch a sticky overflow.
module request_returner
  import types_def::*;
#(
  parameter int DATA_WIDTH  = data_width,
  parameter int INDEX_WIDTH = read_entries_log,
  parameter int RD_DEPTH    = RET_RD_DEPTH,
  parameter int WR_DEPTH    = RET_WR_DEPTH,
  parameter int AF_MARGIN   = 2
) (
  input logic               clk,
  input logic               rst_n,
  request_returner_if.slave bus
);
  logic                              push_rd;
  logic                              push_wr;
  logic                              rd_drop;
  logic                              wr_drop;
  logic [DATA_WIDTH+INDEX_WIDTH-1:0] rd_head;

  assign push_rd = bus.in_valid && (bus.in_type == RT_READ);
  assign push_wr = bus.in_valid && (bus.in_type == RT_WRITE);

  ret_fifo #(
    .WIDTH     (DATA_WIDTH + INDEX_WIDTH),
    .DEPTH     (RD_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_rd),
    .push_data   ({bus.in_data, bus.in_index}),
    .pop         (bus.rd_ready),
    .head        (rd_head),
    .valid       (bus.rd_valid),
    .count       (bus.rd_count),
    .full        (bus.rd_full),
    .almost_full (bus.rd_almost_full),
    .drop_pulse  (rd_drop)
  );

  assign bus.rd_data  = rd_head[DATA_WIDTH+INDEX_WIDTH-1:INDEX_WIDTH];
  assign bus.rd_index = rd_head[INDEX_WIDTH-1:0];

  ret_fifo #(
    .WIDTH     (INDEX_WIDTH),
    .DEPTH     (WR_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_wr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_wr),
    .push_data   (bus.in_index),
    .pop         (bus.wr_ready),
    .head        (bus.wr_index),
    .valid       (bus.wr_valid),
    .count       (bus.wr_count),
    .full        (bus.wr_full),
    .almost_full (bus.wr_almost_full),
    .drop_pulse  (wr_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)                  bus.overflow <= 1'b0;
    else if (rd_drop || wr_drop) bus.overflow <= 1'b1;
  end

endmodule
